// File: rtl/xor_frame_sequencer_if.sv
// Word-in / checksum-out handshake bundle for xor_frame_sequencer.
// PARITY_OUT_EN adds the parity bit of the held checksum.
interface xor_frame_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic             start;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] sum;
  logic             sum_valid;
  logic             sum_ack;
  logic             busy;
  logic [CW-1:0]    cnt;
`ifdef PARITY_OUT_EN
  logic             par;
`endif

  modport slave (
    input  start, din, din_valid, sum_ack,
    output din_ready, sum, sum_valid, busy, cnt
`ifdef PARITY_OUT_EN
    , output par
`endif
  );

  modport master (
    output start, din, din_valid, sum_ack,
    input  din_ready, sum, sum_valid, busy, cnt
`ifdef PARITY_OUT_EN
    , input par
`endif
  );
endinterface

// File: rtl/xor_frame_sequencer.sv
// Folds LEN words into an XOR checksum per frame and holds it until acknowledged.
// Optional PARITY_OUT_EN drives bus.par = ^sum.
module xor_frame_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  xor_frame_sequencer_if.slave  bus
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic             sum_valid;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= ACC;
          acc   <= '0;
          cnt   <= '0;
        end
        ACC: if (bus.din_valid) begin
          // final word bypasses acc so sum appears on the accepting edge
          if (cnt == LAST) begin
            sum       <= acc ^ bus.din;
            sum_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            acc <= acc ^ bus.din;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (bus.sum_ack) begin
          sum_valid <= 1'b0;
          if (bus.start) begin
            state <= ACC;
            acc   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready = (state == ACC);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum;
  assign bus.sum_valid = sum_valid;
  assign bus.cnt       = cnt;
`ifdef PARITY_OUT_EN
  assign bus.par       = ^sum;
`endif
endmodule

// File: tb/tb_xor_frame_sequencer.sv
// Directed + randomized bench: expected checksum is the XOR fold of each frame's word list.
module tb_xor_frame_sequencer;
  localparam int W = 8;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  xor_frame_sequencer_if #(.WIDTH(W), .LEN(LEN)) bus ();
  xor_frame_sequencer_if #(.WIDTH(W), .LEN(1))   bus1 ();

  xor_frame_sequencer #(.WIDTH(W), .LEN(LEN)) dut  (.clk(clk), .clr_n(clr_n), .bus(bus));
  xor_frame_sequencer #(.WIDTH(W), .LEN(1))   dut1 (.clk(clk), .clr_n(clr_n), .bus(bus1));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] words [LEN];
  logic [W-1:0] last_sum = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sum(input string tag);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(last_sum));
`ifdef PARITY_OUT_EN
    chk({tag, "_par"}, 32'(bus.par), 32'(^last_sum));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("enter_acc_ready", 32'(bus.din_ready), 32'd1);
    chk("enter_acc_cnt", 32'(bus.cnt), 32'd0);
  endtask

  // Feeds words[] with 'gap' idle cycles between words; optional start pulse inside the frame.
  task automatic run_frame(input int gap, input bit start_glitch);
    logic [W-1:0] fold;
    fold = '0;
    foreach (words[i]) fold ^= words[i];
    for (int i = 0; i < LEN; i++) begin
      bus.din = words[i];
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
      bus.din = W'($urandom);
      if (i < LEN - 1) begin
        chk("cnt_step", 32'(bus.cnt), 32'(i + 1));
        chk("no_early_valid", 32'(bus.sum_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          bus.start = start_glitch && (g == 0);
          tick();
          bus.start = 1'b0;
          chk("gap_cnt_hold", 32'(bus.cnt), 32'(i + 1));
        end
      end else begin
        last_sum = fold;
        chk("done_valid", 32'(bus.sum_valid), 32'd1);
        chk("done_ready", 32'(bus.din_ready), 32'd0);
        chk("done_cnt", 32'(bus.cnt), 32'd0);
        chk_sum("done");
      end
    end
  endtask

  task automatic finish_frame(input int hold, input bit next);
    for (int h = 0; h < hold; h++) begin
      bus.din_valid = 1'b1;  // must be ignored while result is pending
      tick();
      bus.din_valid = 1'b0;
      chk("hold_valid", 32'(bus.sum_valid), 32'd1);
      chk("hold_cnt", 32'(bus.cnt), 32'd0);
      chk_sum("hold");
    end
    bus.sum_ack = 1'b1;
    bus.start = next;
    tick();
    bus.sum_ack = 1'b0;
    bus.start = 1'b0;
    chk("ack_valid", 32'(bus.sum_valid), 32'd0);
    chk("ack_busy", 32'(bus.busy), 32'(next));
    chk("ack_ready", 32'(bus.din_ready), 32'(next));
    chk_sum("ack_keep");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sum"}, 32'(bus.sum), 32'd0);
    chk({tag, "_valid"}, 32'(bus.sum_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.din_ready), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.cnt), 32'd0);
  endtask

  initial begin
    bit b2b;
    bus.start = 0; bus.din = '0; bus.din_valid = 0; bus.sum_ack = 0;
    bus1.start = 0; bus1.din = '0; bus1.din_valid = 0; bus1.sum_ack = 0;

    // reset
    repeat (2) tick();
    clr_n = 1'b1;
    tick();
    last_sum = '0;
    chk_reset("reset");
    bus.sum_ack = 1'b1;  // ack in IDLE has no effect
    tick();
    bus.sum_ack = 1'b0;
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);

    // basic frame, result held 3 cycles
    words = '{8'h01, 8'h02, 8'h04, 8'h08};
    begin_frame();
    run_frame(0, 1'b0);
    chk("basic_0F", 32'(bus.sum), 32'h0F);
    finish_frame(3, 1'b0);

    // gaps between words
    words = '{8'hAA, 8'hFF, 8'h00, 8'h55};
    begin_frame();
    run_frame(2, 1'b0);
    chk("gap_00", 32'(bus.sum), 32'h00);
    finish_frame(0, 1'b0);

    // start inside ACC ignored, din in DONE ignored, back-to-back restart
    words = '{8'h11, 8'h22, 8'h44, 8'h88};
    begin_frame();
    run_frame(1, 1'b1);
    chk("glitch_FF", 32'(bus.sum), 32'hFF);
    finish_frame(2, 1'b1);
    words = '{8'h3C, 8'hC3, 8'h5A, 8'h01};
    run_frame(0, 1'b0);
    finish_frame(1, 1'b0);

    // abort mid-frame
    begin_frame();
    for (int i = 0; i < 2; i++) begin
      bus.din = W'($urandom); bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
    chk("pre_abort_cnt", 32'(bus.cnt), 32'd2);
    #2 clr_n = 1'b0;
    #1;
    last_sum = '0;
    chk_reset("abort");
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    words = '{8'h10, 8'h20, 8'h40, 8'h80};
    begin_frame();
    run_frame(0, 1'b0);
    chk("post_abort_F0", 32'(bus.sum), 32'hF0);
    finish_frame(0, 1'b0);

`ifdef PARITY_OUT_EN
    words = '{8'h07, 8'h00, 8'h00, 8'h00};
    begin_frame();
    run_frame(0, 1'b0);
    chk("par_07", 32'(bus.par), 32'd1);
    finish_frame(0, 1'b0);
`endif

    // randomized frames against the fold model
    b2b = 1'b0;
    for (int f = 0; f < 20; f++) begin
      foreach (words[i]) words[i] = W'($urandom);
      if (!b2b) begin_frame();
      run_frame($urandom_range(0, 2), 1'(f % 3 == 0));
      b2b = 1'($urandom_range(0, 1));
      finish_frame($urandom_range(0, 2), b2b);
    end
    if (b2b) begin
      words = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(0, 1'b0);
      finish_frame(0, 1'b0);
    end

    // single-word frames
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("len1_ready", 32'(bus1.din_ready), 32'd1);
    bus1.din = 8'h3C; bus1.din_valid = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    chk("len1_valid", 32'(bus1.sum_valid), 32'd1);
    chk("len1_sum", 32'(bus1.sum), 32'h3C);
    bus1.sum_ack = 1'b1;
    tick();
    bus1.sum_ack = 1'b0;
    chk("len1_ack", 32'(bus1.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
